can_rx_frame: RTL and testbench



---
 rtl/can_pkg.sv | 36 +++
 rtl/can_bit_destuff.sv | 55 +++++
 rtl/can_rx_frame.sv | 254 +++++++++++++++++++++++++
 tb/tb_can_rx_frame.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// Shared CAN definitions: CRC-15 polynomial, frame field lengths and the
// receive state encoding used by the receive and transmit paths.
package can_pkg;

    localparam logic [14:0] CAN_CRC_POLY  = 15'h4599;

    localparam int unsigned CAN_ARB_LEN   = 11;
    localparam int unsigned CAN_CTRL_LEN  = 7;
    localparam int unsigned CAN_DATA_LEN  = 46;
    localparam int unsigned CAN_CRC_LEN   = 15;
    localparam int unsigned CAN_EOF_LEN   = 7;

    // rw + addr[14:0] + data[15:0]; the rest of the DATA field is padding
    localparam int unsigned CAN_WORD_LEN  = 32;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ARB       = 4'd1,
        ST_CTRL      = 4'd2,
        ST_DATA      = 4'd3,
        ST_CRC       = 4'd4,
        ST_CRC_DELIM = 4'd5,
        ST_ACK       = 4'd6,
        ST_ACK_DELIM = 4'd7,
        ST_EOF       = 4'd8,
        ST_ERROR     = 4'd9
    } can_rx_state_t;

    // One serial CRC-15 step for a single bus bit
    function automatic logic [14:0] crc15_step(input logic [14:0] crc,
                                               input logic        b,
                                               input logic [14:0] poly);
        return {crc[13:0], 1'b0} ^ ((b ^ crc[14]) ? poly : 15'h0000);
    endfunction

endpackage

// File: rtl/can_bit_destuff.sv
// Bit destuffer: after five identical bits the next one is a stuff bit and
// is dropped in the same cycle it arrives. A stuff bit equal to the
// preceding bit flags a stuff error. `clear` makes the current bit start a
// fresh run (used while idle so SOF begins the count).
module can_bit_destuff
    import can_pkg::*;
(
    input  logic clk,
    input  logic n_rst,
    input  logic bit_valid,
    input  logic rx_bit,
    input  logic enable,
    input  logic clear,
    output logic out_valid,
    output logic out_bit,
    output logic stuff_err
);

    logic [2:0] run_q, run_d, run_eff;
    logic       last_q, last_d;
    logic       is_stuff;
    logic       take;

    // Classify the incoming bit and advance the run-length counter
    always_comb begin
        run_eff   = clear ? 3'd0 : run_q;
        is_stuff  = (run_eff == 3'd5);
        take      = bit_valid && enable;
        out_bit   = rx_bit;
        out_valid = take && !is_stuff;
        stuff_err = take && is_stuff && (rx_bit == last_q);
        run_d     = run_q;
        last_d    = last_q;
        if (take) begin
            last_d = rx_bit;
            if (!is_stuff && (run_eff != 3'd0) && (rx_bit == last_q)) begin
                run_d = run_eff + 3'd1;
            end else begin
                run_d = 3'd1;
            end
        end
    end

    // Run-length state
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            run_q  <= '0;
            last_q <= 1'b0;
        end else begin
            run_q  <= run_d;
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/can_rx_frame.sv
// CAN receive frame decoder: destuffs the bus, walks the fixed frame layout,
// checks CRC-15 and frame form, drives the ACK slot and presents the decoded
// register-access word on a one-cycle frame_valid pulse.
module can_rx_frame
    import can_pkg::*;
#(
    parameter logic [14:0] POLY     = CAN_CRC_POLY,
    parameter int unsigned EOF_LEN  = CAN_EOF_LEN,
    parameter int unsigned IDLE_LEN = 11
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        bit_valid,
    input  logic        rx_bit,
    output logic        ack_drive,
    output logic        busy,
    output logic        frame_valid,
    output logic [10:0] arb_id,
    output logic [6:0]  ctrl,
    output logic        rw,
    output logic [14:0] addr,
    output logic [15:0] wdata,
    output logic        crc_error,
    output logic        stuff_error,
    output logic        form_error
);

    can_rx_state_t state_q, state_d;
    logic [6:0]    cnt_q, cnt_d;
    logic [14:0]   crc_q, crc_d;
    logic [14:0]   rcrc_q, rcrc_d;
    logic [10:0]   arb_sr_q, arb_sr_d;
    logic [6:0]    ctrl_sr_q, ctrl_sr_d;
    logic [31:0]   word_sr_q, word_sr_d;
    logic [10:0]   arb_id_q, arb_id_d;
    logic [6:0]    ctrl_q, ctrl_d;
    logic          rw_q, rw_d;
    logic [14:0]   addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic          ack_q, ack_d, busy_q, busy_d;
    logic          fv_q, fv_d, crc_err_q, crc_err_d;
    logic          stf_err_q, stf_err_d, frm_err_q, frm_err_d;

    logic ds_enable, ds_clear, ds_valid, ds_bit, ds_err;
    logic field_last;

    assign ds_enable  = (state_q inside {ST_IDLE, ST_ARB, ST_CTRL, ST_DATA, ST_CRC});
    assign ds_clear   = (state_q == ST_IDLE);
    assign field_last = (cnt_q == 7'd1);

    can_bit_destuff u_destuff (
        .clk       (clk),
        .n_rst     (n_rst),
        .bit_valid (bit_valid),
        .rx_bit    (rx_bit),
        .enable    (ds_enable),
        .clear     (ds_clear),
        .out_valid (ds_valid),
        .out_bit   (ds_bit),
        .stuff_err (ds_err)
    );

    // Frame FSM, field counter, CRC and field shift registers
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        crc_d     = crc_q;
        rcrc_d    = rcrc_q;
        arb_sr_d  = arb_sr_q;
        ctrl_sr_d = ctrl_sr_q;
        word_sr_d = word_sr_q;
        arb_id_d  = arb_id_q;
        ctrl_d    = ctrl_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        fv_d      = 1'b0;
        crc_err_d = 1'b0;
        stf_err_d = 1'b0;
        frm_err_d = 1'b0;
        if (bit_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_bit) begin
                        state_d = ST_ARB;
                        cnt_d   = 7'(CAN_ARB_LEN);
                        crc_d   = crc15_step('0, rx_bit, POLY);
                    end
                end
                ST_ARB, ST_CTRL, ST_DATA, ST_CRC: begin
                    if (ds_err) begin
                        stf_err_d = 1'b1;
                        state_d   = ST_ERROR;
                        cnt_d     = 7'(IDLE_LEN);
                    end else if (ds_valid) begin
                        if (state_q != ST_CRC) begin
                            crc_d = crc15_step(crc_q, ds_bit, POLY);
                        end
                        cnt_d = cnt_q - 7'd1;
                        case (state_q)
                            ST_ARB: begin
                                arb_sr_d = {arb_sr_q[9:0], ds_bit};
                                if (field_last) begin
                                    state_d = ST_CTRL;
                                    cnt_d   = 7'(CAN_CTRL_LEN);
                                end
                            end
                            ST_CTRL: begin
                                ctrl_sr_d = {ctrl_sr_q[5:0], ds_bit};
                                if (field_last) begin
                                    state_d = ST_DATA;
                                    cnt_d   = 7'(CAN_DATA_LEN);
                                end
                            end
                            ST_DATA: begin
                                // only the leading word bits are kept; padding is CRC-only
                                if (cnt_q > 7'(CAN_DATA_LEN - CAN_WORD_LEN)) begin
                                    word_sr_d = {word_sr_q[30:0], ds_bit};
                                end
                                if (field_last) begin
                                    state_d = ST_CRC;
                                    cnt_d   = 7'(CAN_CRC_LEN);
                                end
                            end
                            default: begin
                                rcrc_d = {rcrc_q[13:0], ds_bit};
                                if (field_last) begin
                                    state_d = ST_CRC_DELIM;
                                    cnt_d   = '0;
                                end
                            end
                        endcase
                    end
                end
                ST_CRC_DELIM: begin
                    if (!rx_bit) begin
                        frm_err_d = 1'b1;
                        state_d   = ST_ERROR;
                        cnt_d     = 7'(IDLE_LEN);
                    end else if (crc_q != rcrc_q) begin
                        crc_err_d = 1'b1;
                        state_d   = ST_ERROR;
                        cnt_d     = 7'(IDLE_LEN);
                    end else begin
                        state_d = ST_ACK;
                    end
                end
                ST_ACK: begin
                    state_d = ST_ACK_DELIM;
                end
                ST_ACK_DELIM: begin
                    if (!rx_bit) begin
                        frm_err_d = 1'b1;
                        state_d   = ST_ERROR;
                        cnt_d     = 7'(IDLE_LEN);
                    end else begin
                        state_d = ST_EOF;
                        cnt_d   = 7'(EOF_LEN);
                    end
                end
                ST_EOF: begin
                    if (!rx_bit) begin
                        frm_err_d = 1'b1;
                        state_d   = ST_ERROR;
                        cnt_d     = 7'(IDLE_LEN);
                    end else if (field_last) begin
                        fv_d     = 1'b1;
                        state_d  = ST_IDLE;
                        cnt_d    = '0;
                        arb_id_d = arb_sr_q;
                        ctrl_d   = ctrl_sr_q;
                        rw_d     = word_sr_q[31];
                        addr_d   = word_sr_q[30:16];
                        wdata_d  = word_sr_q[15:0];
                    end else begin
                        cnt_d = cnt_q - 7'd1;
                    end
                end
                ST_ERROR: begin
                    if (!rx_bit) begin
                        cnt_d = 7'(IDLE_LEN);
                    end else if (field_last) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 7'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        ack_d  = (state_d == ST_ACK);
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            crc_q     <= '0;
            rcrc_q    <= '0;
            arb_sr_q  <= '0;
            ctrl_sr_q <= '0;
            word_sr_q <= '0;
            arb_id_q  <= '0;
            ctrl_q    <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            fv_q      <= 1'b0;
            crc_err_q <= 1'b0;
            stf_err_q <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            crc_q     <= crc_d;
            rcrc_q    <= rcrc_d;
            arb_sr_q  <= arb_sr_d;
            ctrl_sr_q <= ctrl_sr_d;
            word_sr_q <= word_sr_d;
            arb_id_q  <= arb_id_d;
            ctrl_q    <= ctrl_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            fv_q      <= fv_d;
            crc_err_q <= crc_err_d;
            stf_err_q <= stf_err_d;
            frm_err_q <= frm_err_d;
        end
    end

    assign ack_drive   = ack_q;
    assign busy        = busy_q;
    assign frame_valid = fv_q;
    assign arb_id      = arb_id_q;
    assign ctrl        = ctrl_q;
    assign rw          = rw_q;
    assign addr        = addr_q;
    assign wdata       = wdata_q;
    assign crc_error   = crc_err_q;
    assign stuff_error = stf_err_q;
    assign form_error  = frm_err_q;

endmodule

// File: tb/tb_can_rx_frame.sv
// Bench for can_rx_frame: builds bus streams from frame fields (CRC,
// stuffing, error injection), keeps a per-sample expectation queue and
// compares every DUT output on every cycle.
module tb_can_rx_frame;

    localparam logic [14:0] POLY = 15'h4599;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        bit_valid = 1'b0;
    logic        rx_bit = 1'b1;
    logic        ack_drive, busy, frame_valid, rw;
    logic [10:0] arb_id;
    logic [6:0]  ctrl;
    logic [14:0] addr;
    logic [15:0] wdata;
    logic        crc_error, stuff_error, form_error;

    always #5 clk = ~clk;

    can_rx_frame #(.POLY(15'h4599), .EOF_LEN(7), .IDLE_LEN(11)) dut (
        .clk(clk), .n_rst(n_rst), .bit_valid(bit_valid), .rx_bit(rx_bit),
        .ack_drive(ack_drive), .busy(busy), .frame_valid(frame_valid),
        .arb_id(arb_id), .ctrl(ctrl), .rw(rw), .addr(addr), .wdata(wdata),
        .crc_error(crc_error), .stuff_error(stuff_error), .form_error(form_error)
    );

    typedef struct {
        bit          busy, ack, fv, ce, se, fe;
        logic [10:0] arb;
        logic [6:0]  ctrl;
        logic        rw;
        logic [14:0] addr;
        logic [15:0] data;
    } exp_t;

    exp_t  expq[$];
    exp_t  cur;
    exp_t  m_e;
    bit    txq[$];
    bit    ub[$];
    bit    sb[$];
    int    smap[$];
    int    spos[$];
    logic [10:0] f_arb;
    logic [6:0]  f_ctrl;
    logic        f_rw;
    logic [14:0] f_addr;
    logic [15:0] f_data;
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // CRC-15 of the n low bits of v, most significant first
    function automatic logic [14:0] crc_bits(input logic [127:0] v, input int n);
        logic [14:0] c;
        logic        fb;
        c = '0;
        for (int i = n - 1; i >= 0; i--) begin
            fb = v[i] ^ c[14];
            c  = {c[13:0], 1'b0};
            if (fb) c = c ^ POLY;
        end
        return c;
    endfunction

    // Insert a complementary bit after every run of five identical bits
    task automatic do_stuff();
        int run;
        bit last;
        run = 0;
        last = 1'b0;
        sb.delete(); smap.delete(); spos.delete();
        foreach (ub[i]) begin
            if (run == 5) begin
                spos.push_back(sb.size());
                sb.push_back(!last);
                last = !last;
                run = 1;
            end
            smap.push_back(sb.size());
            sb.push_back(ub[i]);
            if (run > 0 && ub[i] == last) run++;
            else run = 1;
            last = ub[i];
        end
    endtask

    task automatic build_frame(input logic [10:0] a, input logic [6:0] c, input logic r,
                               input logic [14:0] ad, input logic [15:0] d, input int flip);
        logic [64:0] head;
        logic [14:0] cr;
        f_arb = a; f_ctrl = c; f_rw = r; f_addr = ad; f_data = d;
        head = {1'b0, a, c, r, ad, d, 14'h0000};
        cr = crc_bits({63'b0, head}, 65);
        if (flip >= 0) cr[flip] = ~cr[flip];
        ub.delete();
        for (int i = 64; i >= 0; i--) ub.push_back(head[i]);
        for (int i = 14; i >= 0; i--) ub.push_back(cr[i]);
        do_stuff();
    endtask

    task automatic push(input bit b, input bit bz, input bit ak, input bit fv,
                        input bit ce, input bit se, input bit fe);
        exp_t e;
        e.busy = bz; e.ack = ak; e.fv = fv; e.ce = ce; e.se = se; e.fe = fe;
        e.arb = f_arb; e.ctrl = f_ctrl; e.rw = f_rw; e.addr = f_addr; e.data = f_data;
        txq.push_back(b);
        expq.push_back(e);
    endtask

    // SOF..CRC; at err_at the stuff bit is replaced by a dominant bit
    task automatic add_body(input int err_at);
        foreach (sb[i]) begin
            if (i == err_at) begin
                push(1'b0, 1, 0, 0, 0, 1, 0);
                return;
            end
            push(sb[i], 1, 0, 0, 0, 0, 0);
        end
    endtask

    // kind 0 clean, 1 CRC mismatch, 2 dominant CRC_DELIM, 3 dominant EOF bit 4
    task automatic add_tail(input int kind);
        if (kind == 1) begin push(1'b1, 1, 0, 0, 1, 0, 0); return; end
        if (kind == 2) begin push(1'b0, 1, 0, 0, 0, 0, 1); return; end
        push(1'b1, 1, 1, 0, 0, 0, 0);
        push(1'b0, 1, 0, 0, 0, 0, 0);
        push(1'b1, 1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 7; k++) begin
            if (kind == 3 && k == 4) begin push(1'b0, 1, 0, 0, 0, 0, 1); return; end
            if (k == 7) push(1'b1, 0, 0, 1, 0, 0, 0);
            else        push(1'b1, 1, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic add_recovery(input bit restart);
        if (restart) begin
            repeat (5) push(1'b1, 1, 0, 0, 0, 0, 0);
            push(1'b0, 1, 0, 0, 0, 0, 0);
        end
        repeat (10) push(1'b1, 1, 0, 0, 0, 0, 0);
        push(1'b1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic add_idle(input int n);
        repeat (n) push(1'b1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic send_all(input int gap);
        bit b;
        while (txq.size() > 0) begin
            b = txq.pop_front();
            repeat (gap - 1) begin
                @(negedge clk);
                bit_valid = 1'b0;
            end
            @(negedge clk);
            bit_valid = 1'b1;
            rx_bit = b;
        end
        @(negedge clk);
        bit_valid = 1'b0;
        rx_bit = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Expected outputs for the cycle after each clock edge
    always @(posedge clk) begin
        if (!n_rst) begin
            cur = '{default: '0};
        end else begin
            cur.fv = 0; cur.ce = 0; cur.se = 0; cur.fe = 0;
            if (bit_valid) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL model_underrun: sampled bit with no expectation at %0t", $time);
                end else begin
                    m_e = expq.pop_front();
                    cur.busy = m_e.busy; cur.ack = m_e.ack; cur.fv = m_e.fv;
                    cur.ce = m_e.ce; cur.se = m_e.se; cur.fe = m_e.fe;
                    if (m_e.fv) begin
                        cur.arb = m_e.arb; cur.ctrl = m_e.ctrl; cur.rw = m_e.rw;
                        cur.addr = m_e.addr; cur.data = m_e.data;
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison of all outputs
    always @(negedge clk) begin
        chk("busy",        32'(busy),        32'(cur.busy));
        chk("ack_drive",   32'(ack_drive),   32'(cur.ack));
        chk("frame_valid", 32'(frame_valid), 32'(cur.fv));
        chk("crc_error",   32'(crc_error),   32'(cur.ce));
        chk("stuff_error", 32'(stuff_error), 32'(cur.se));
        chk("form_error",  32'(form_error),  32'(cur.fe));
        chk("arb_id",      32'(arb_id),      32'(cur.arb));
        chk("ctrl",        32'(ctrl),        32'(cur.ctrl));
        chk("rw",          32'(rw),          32'(cur.rw));
        chk("addr",        32'(addr),        32'(cur.addr));
        chk("wdata",       32'(wdata),       32'(cur.data));
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int k;
        cur = '{default: '0};
        repeat (3) @(negedge clk);
        #2 n_rst = 1'b1;

        // model pins
        chk("pin_crc_1",  32'(crc_bits(128'd1, 1)), 32'h4599);
        chk("pin_crc_10", 32'(crc_bits(128'd2, 2)), 32'h4EAB);
        ub.delete();
        repeat (7) ub.push_back(1'b0);
        do_stuff();
        chk("pin_stuff_len", 32'(sb.size()), 32'd8);
        chk("pin_stuff_bit", 32'(sb[5]), 32'd1);

        // clean frame, back-to-back strobes
        build_frame(11'h123, 7'h08, 1'b1, 15'h0042, 16'hBEEF, -1);
        add_body(-1); add_tail(0); add_idle(3);
        send_all(1);
        chk("lit_arb",   32'(arb_id), 32'h123);
        chk("lit_ctrl",  32'(ctrl),   32'h08);
        chk("lit_rw",    32'(rw),     32'h1);
        chk("lit_addr",  32'(addr),   32'h0042);
        chk("lit_wdata", 32'(wdata),  32'hBEEF);

        // flipped CRC bit
        build_frame(11'h123, 7'h08, 1'b1, 15'h0042, 16'hBEEF, 3);
        add_body(-1); add_tail(1); add_recovery(0); add_idle(2);
        send_all(1);

        // stuff bit in the data word replaced by a dominant bit
        build_frame(11'h123, 7'h08, 1'b1, 15'h0042, 16'h0000, -1);
        k = -1;
        foreach (spos[j]) if (k < 0 && spos[j] > smap[35] && sb[spos[j]]) k = spos[j];
        chk("stuff_site_found", 32'(k >= 0), 32'd1);
        add_body(k); add_recovery(1); add_idle(2);
        send_all(1);

        // dominant CRC_DELIM
        build_frame(11'h123, 7'h08, 1'b1, 15'h0042, 16'hBEEF, -1);
        add_body(-1); add_tail(2); add_recovery(0); add_idle(2);
        send_all(1);

        // dominant EOF bit 4
        build_frame(11'h123, 7'h08, 1'b1, 15'h0042, 16'hBEEF, -1);
        add_body(-1); add_tail(3); add_recovery(0); add_idle(2);
        send_all(1);
        chk("lit_hold_wdata", 32'(wdata), 32'hBEEF);

        // clean frame, one strobe every 4th cycle
        build_frame(11'h5A5, 7'h3C, 1'b0, 15'h7FFF, 16'h1234, -1);
        add_body(-1); add_tail(0); add_idle(2);
        send_all(4);
        chk("lit_gap_arb",   32'(arb_id), 32'h5A5);
        chk("lit_gap_addr",  32'(addr),   32'h7FFF);
        chk("lit_gap_wdata", 32'(wdata),  32'h1234);

        // reset during DATA bit 20, then a clean frame
        build_frame(11'h2AA, 7'h11, 1'b0, 15'h1357, 16'hCAFE, -1);
        for (int i = 0; i <= smap[39]; i++) push(sb[i], 1, 0, 0, 0, 0, 0);
        send_all(1);
        @(negedge clk);
        #2 n_rst = 1'b0;
        repeat (3) @(negedge clk);
        #2 n_rst = 1'b1;
        @(negedge clk);
        chk("lit_rst_busy",  32'(busy),  32'd0);
        chk("lit_rst_wdata", 32'(wdata), 32'd0);
        build_frame(11'h123, 7'h08, 1'b1, 15'h0042, 16'hBEEF, -1);
        add_body(-1); add_tail(0); add_idle(2);
        send_all(1);
        chk("lit_post_rst_wdata", 32'(wdata), 32'hBEEF);

        // all-recessive bus
        add_idle(100);
        send_all(1);

        chk("exp_drained", 32'(expq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
